// File: rtl/eqed_inject_sched.sv
// eqed_inject_sched: sweeps every (FF, inject-cycle) pair of a mux-instrumented
// design, flips one FF in one cycle per trial, and flags trials whose MISR
// signature equals the golden signature. Hits land in an exclusion table so a
// later sweep moves on to further candidates.
//
// Handshake note: there is no valid/ready pair here. start and excl_wr are
// single-cycle requests that are accepted only in IDLE or DONE and silently
// dropped otherwise. hit_valid is a one-cycle strobe with no back-pressure, and
// hit_ff/hit_cyc hold their value until the next hit.
module eqed_inject_sched #(
  parameter int NUM_FF      = 8,
  parameter int FF_W        = 3,
  parameter int CYC_W       = 4,
  parameter int MAX_INJ_CYC = 4,
  parameter int WIN         = 5,
  parameter int SIG_W       = 18,
  parameter int EXCL_DEPTH  = 4,
  parameter int AUTO_EXCL   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              excl_wr,
  input  logic [FF_W-1:0]                   excl_ff,
  input  logic [CYC_W-1:0]                  excl_cyc,
  input  logic [SIG_W-1:0]                  misr_sig,
  input  logic [SIG_W-1:0]                  golden_sig,
  output logic                              dut_rst,
  output logic [NUM_FF-1:0]                 inject_sel,
  output logic                              hit_valid,
  output logic [FF_W-1:0]                   hit_ff,
  output logic [CYC_W-1:0]                  hit_cyc,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(EXCL_DEPTH+1)-1:0]   excl_count,
  output logic                              excl_full,
  output logic [2:0]                        dbg_state
);

  localparam int CNT_W = $clog2(EXCL_DEPTH + 1);
  localparam int T_W   = $clog2(WIN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRST  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_ADV   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [FF_W-1:0]   cur_ff_q, cur_ff_d;
  logic [CYC_W-1:0]  cur_cyc_q, cur_cyc_d;
  logic [T_W-1:0]    t_q, t_d;
  logic              hit_valid_q, hit_valid_d;
  logic [FF_W-1:0]   hit_ff_q, hit_ff_d;
  logic [CYC_W-1:0]  hit_cyc_q, hit_cyc_d;
  logic [FF_W-1:0]   tff_q [EXCL_DEPTH];
  logic [FF_W-1:0]   tff_d [EXCL_DEPTH];
  logic [CYC_W-1:0]  tcyc_q [EXCL_DEPTH];
  logic [CYC_W-1:0]  tcyc_d [EXCL_DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cur_excl, wr_dup, full;
  logic [FF_W-1:0]   nxt_ff;
  logic [CYC_W-1:0]  nxt_cyc;

  assign full = (cnt_q == CNT_W'(EXCL_DEPTH));

  // Table lookups (current candidate, pending host write) and next-candidate arithmetic
  always_comb begin
    cur_excl = 1'b0;
    wr_dup   = 1'b0;
    for (int i = 0; i < EXCL_DEPTH; i++) begin
      if (i < int'(cnt_q)) begin
        if (tff_q[i] == cur_ff_q && tcyc_q[i] == cur_cyc_q) cur_excl = 1'b1;
        if (tff_q[i] == excl_ff  && tcyc_q[i] == excl_cyc)  wr_dup   = 1'b1;
      end
    end
    if (cur_ff_q == FF_W'(NUM_FF - 1)) begin
      nxt_ff  = '0;
      nxt_cyc = cur_cyc_q + CYC_W'(1);
    end else begin
      nxt_ff  = cur_ff_q + FF_W'(1);
      nxt_cyc = cur_cyc_q;
    end
  end

  // Sweep FSM next-state, table updates and trial outputs
  always_comb begin
    state_d     = state_q;
    cur_ff_d    = cur_ff_q;
    cur_cyc_d   = cur_cyc_q;
    t_d         = t_q;
    hit_valid_d = 1'b0;
    hit_ff_d    = hit_ff_q;
    hit_cyc_d   = hit_cyc_q;
    tff_d       = tff_q;
    tcyc_d      = tcyc_q;
    cnt_d       = cnt_q;
    dut_rst     = 1'b1;
    inject_sel  = '0;

    // Host writes land before a same-cycle start, so the sweep sees them.
    if ((state_q == S_IDLE || state_q == S_DONE) && excl_wr && !wr_dup && !full) begin
      for (int i = 0; i < EXCL_DEPTH; i++) begin
        if (i == int'(cnt_q)) begin
          tff_d[i]  = excl_ff;
          tcyc_d[i] = excl_cyc;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ADV;
          cur_ff_d  = '0;
          cur_cyc_d = CYC_W'(1);
        end
      end
      S_ADV: begin
        if (cur_excl) begin
          cur_ff_d  = nxt_ff;
          cur_cyc_d = nxt_cyc;
        end else if (int'(cur_cyc_q) > MAX_INJ_CYC) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRST;
        end
      end
      S_DRST: begin
        t_d     = T_W'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        dut_rst = 1'b0;
        if (int'(t_q) == int'(cur_cyc_q)) inject_sel = NUM_FF'(1) << cur_ff_q;
        t_d = t_q + T_W'(1);
        if (int'(t_q) == WIN) state_d = S_CHECK;
      end
      S_CHECK: begin
        dut_rst = 1'b0;
        if (misr_sig == golden_sig) begin
          hit_valid_d = 1'b1;
          hit_ff_d    = cur_ff_q;
          hit_cyc_d   = cur_cyc_q;
          // A pair that just ran cannot already be in the table, so no duplicate check.
          if (AUTO_EXCL != 0 && !full) begin
            for (int i = 0; i < EXCL_DEPTH; i++) begin
              if (i == int'(cnt_q)) begin
                tff_d[i]  = cur_ff_q;
                tcyc_d[i] = cur_cyc_q;
              end
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        cur_ff_d  = nxt_ff;
        cur_cyc_d = nxt_cyc;
        state_d   = S_ADV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, candidate, hit and exclusion-table registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_ff_q    <= '0;
      cur_cyc_q   <= '0;
      t_q         <= '0;
      hit_valid_q <= 1'b0;
      hit_ff_q    <= '0;
      hit_cyc_q   <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < EXCL_DEPTH; i++) begin
        tff_q[i]  <= '0;
        tcyc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_ff_q    <= cur_ff_d;
      cur_cyc_q   <= cur_cyc_d;
      t_q         <= t_d;
      hit_valid_q <= hit_valid_d;
      hit_ff_q    <= hit_ff_d;
      hit_cyc_q   <= hit_cyc_d;
      cnt_q       <= cnt_d;
      tff_q       <= tff_d;
      tcyc_q      <= tcyc_d;
    end
  end

  assign hit_valid  = hit_valid_q;
  assign hit_ff     = hit_ff_q;
  assign hit_cyc    = hit_cyc_q;
  assign busy       = (state_q == S_ADV) || (state_q == S_DRST) ||
                      (state_q == S_RUN) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign excl_count = cnt_q;
  assign excl_full  = full;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_eqed_inject_sched.sv
// Bench for eqed_inject_sched. A behavioural wrapper stand-in turns each
// observed flip into a per-pair signature; a sweep-level model lists the trials,
// hits, table contents and busy length that each sweep should produce.
module tb_eqed_inject_sched;
  localparam int NUM_FF = 8;
  localparam int MAXC   = 4;
  localparam int WIN    = 5;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst, start, excl_wr;
  logic [2:0]  excl_ff;
  logic [3:0]  excl_cyc;
  logic [17:0] misr_sig, golden_sig;
  logic        dut_rst, hit_valid, busy, done, excl_full;
  logic [7:0]  inject_sel;
  logic [2:0]  hit_ff, dbg_state;
  logic [3:0]  hit_cyc;
  logic [2:0]  excl_count;

  eqed_inject_sched dut (
    .clk(clk), .rst(rst), .start(start), .excl_wr(excl_wr), .excl_ff(excl_ff),
    .excl_cyc(excl_cyc), .misr_sig(misr_sig), .golden_sig(golden_sig),
    .dut_rst(dut_rst), .inject_sel(inject_sel), .hit_valid(hit_valid),
    .hit_ff(hit_ff), .hit_cyc(hit_cyc), .busy(busy), .done(done),
    .excl_count(excl_count), .excl_full(excl_full), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // pairs are encoded {ff[2:0], cyc[3:0]}
  logic [6:0]  tbl[$];
  logic [6:0]  mq[$];
  logic [6:0]  exp_trial_q[$];
  logic [6:0]  exp_hit_q[$];
  logic [6:0]  obs_trial_q[$];
  logic [6:0]  obs_hit_q[$];
  logic [17:0] sig_map [NUM_FF][16];
  int          run_cnt = 0;
  int          busy_cyc = 0;
  int          onehot_bad = 0;

  // Wrapper stand-in and monitor: sampled on the falling edge
  always @(negedge clk) begin
    int ffi;
    if (dut_rst) begin
      run_cnt  = 0;
      misr_sig = '0;
    end else begin
      run_cnt = run_cnt + 1;
      if (inject_sel != '0) begin
        if (!$onehot(inject_sel)) onehot_bad = onehot_bad + 1;
        ffi = 0;
        for (int k = 0; k < NUM_FF; k++) if (inject_sel[k]) ffi = k;
        obs_trial_q.push_back({3'(ffi), 4'(run_cnt)});
        misr_sig = sig_map[ffi][run_cnt & 15];
      end
    end
    if (hit_valid) obs_hit_q.push_back({hit_ff, hit_cyc});
    if (busy) busy_cyc = busy_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_tbl(input logic [6:0] p);
    foreach (tbl[i]) if (tbl[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_mq(input logic [6:0] p);
    foreach (mq[i]) if (mq[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_wr(input logic [6:0] p);
    if (!in_tbl(p) && tbl.size() < DEPTH) tbl.push_back(p);
  endfunction

  // Fresh random golden value; the pairs in mq alias onto it, all others do not.
  task automatic set_matches();
    logic [17:0] v;
    golden_sig = {1'b1, 17'($urandom)};
    for (int f = 0; f < NUM_FF; f++) begin
      for (int c = 0; c < 16; c++) begin
        do v = 18'($urandom); while (v == golden_sig || v == '0);
        sig_map[f][c] = in_mq({3'(f), 4'(c)}) ? golden_sig : v;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tbl.delete();
  endtask

  task automatic excl_write(input logic [6:0] p);
    excl_wr  = 1'b1;
    excl_ff  = p[6:4];
    excl_cyc = p[3:0];
    @(negedge clk);
    excl_wr = 1'b0;
    model_wr(p);
  endtask

  function automatic logic [6:0] rand_pair();
    logic [6:0] p;
    do p = {3'($urandom_range(0, 7)), 4'($urandom_range(1, MAXC))}; while (in_tbl(p));
    return p;
  endfunction

  // One full sweep checked against the model. Optional extras: a write issued
  // together with start, a start poked mid-sweep, a write poked during RUN.
  task automatic sweep(input string tag, input bit with_wr, input logic [6:0] wr_p,
                       input int poke_start_at, input bit poke_wr, input logic [6:0] poke_p);
    int trials, skips, i;
    bit wr_done;
    if (with_wr) model_wr(wr_p);
    exp_trial_q.delete();
    exp_hit_q.delete();
    trials = 0;
    skips  = 0;
    for (int c = 1; c <= MAXC; c++) begin
      for (int f = 0; f < NUM_FF; f++) begin
        if (in_tbl({3'(f), 4'(c)})) skips++;
        else begin
          trials++;
          exp_trial_q.push_back({3'(f), 4'(c)});
          if (in_mq({3'(f), 4'(c)})) begin
            exp_hit_q.push_back({3'(f), 4'(c)});
            if (tbl.size() < DEPTH) tbl.push_back({3'(f), 4'(c)});
          end
        end
      end
    end
    obs_trial_q.delete();
    obs_hit_q.delete();
    busy_cyc   = 0;
    onehot_bad = 0;
    start = 1'b1;
    if (with_wr) begin
      excl_wr  = 1'b1;
      excl_ff  = wr_p[6:4];
      excl_cyc = wr_p[3:0];
    end
    @(negedge clk);
    start   = 1'b0;
    excl_wr = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_done_clr"}, done, 0);
    wr_done = 1'b0;
    i = 1;
    while (!done && i < 3000) begin
      start = (i == poke_start_at);
      if (poke_wr && !wr_done && !dut_rst) begin
        excl_wr  = 1'b1;
        excl_ff  = poke_p[6:4];
        excl_cyc = poke_p[3:0];
        wr_done  = 1'b1;
      end else excl_wr = 1'b0;
      @(negedge clk);
      i++;
    end
    start   = 1'b0;
    excl_wr = 1'b0;
    chk({tag, "_timeout"}, done, 1);
    @(negedge clk);
    chk({tag, "_done_held"}, done, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_busy_cycles"}, busy_cyc, trials * (WIN + 3) + skips + 1);
    chk({tag, "_onehot"}, onehot_bad, 0);
    chk({tag, "_n_trials"}, obs_trial_q.size(), exp_trial_q.size());
    for (int k = 0; k < exp_trial_q.size() && k < obs_trial_q.size(); k++)
      chk({tag, "_trial"}, obs_trial_q[k], exp_trial_q[k]);
    chk({tag, "_n_hits"}, obs_hit_q.size(), exp_hit_q.size());
    for (int k = 0; k < exp_hit_q.size() && k < obs_hit_q.size(); k++)
      chk({tag, "_hit"}, obs_hit_q[k], exp_hit_q[k]);
    chk({tag, "_excl_count"}, excl_count, tbl.size());
    chk({tag, "_excl_full"}, excl_full, tbl.size() == DEPTH);
  endtask

  initial begin
    logic [6:0] p, q;
    int n;
    rst = 1'b1; start = 1'b0; excl_wr = 1'b0; excl_ff = '0; excl_cyc = '0;
    golden_sig = 18'h1;
    mq.delete();
    set_matches();
    @(negedge clk);
    @(negedge clk);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_inject", inject_sel, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_ff", hit_ff, 0);
    chk("rst_hit_cyc", hit_cyc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_excl_count", excl_count, 0);
    chk("rst_excl_full", excl_full, 0);
    rst = 1'b0;
    tbl.delete();
    @(negedge clk);

    // 1: no matching pair, full 32-trial sweep
    sweep("t1", 1'b0, '0, -1, 1'b0, '0);

    // 2: single matching pair (5,4)
    mq.delete();
    mq.push_back({3'd5, 4'd4});
    set_matches();
    sweep("t2", 1'b0, '0, -1, 1'b0, '0);
    chk("t2_hit_ff_held", hit_ff, 5);
    chk("t2_hit_cyc_held", hit_cyc, 4);

    // 3: preloaded pairs are skipped, only (2,1) reported, table full drops it
    do_reset();
    excl_write({3'd6, 4'd4});
    excl_write({3'd7, 4'd2});
    excl_write({3'd3, 4'd3});
    excl_write({3'd4, 4'd1});
    mq.delete();
    foreach (tbl[k]) mq.push_back(tbl[k]);
    mq.push_back({3'd2, 4'd1});
    set_matches();
    sweep("t3", 1'b0, '0, -1, 1'b0, '0);

    // 4: write during RUN ignored; overflow and duplicate writes dropped
    do_reset();
    mq.delete();
    set_matches();
    for (int k = 0; k < 3; k++) excl_write(rand_pair());
    p = rand_pair();
    sweep("t4a", 1'b0, '0, -1, 1'b1, p);
    excl_write(rand_pair());
    excl_write(rand_pair());
    excl_write(tbl[0]);
    chk("t4_excl_count", excl_count, 4);
    chk("t4_excl_full", excl_full, 1);
    sweep("t4b", 1'b0, '0, -1, 1'b0, '0);

    // 5: reset in the third RUN cycle aborts with no hit
    do_reset();
    excl_write({3'd7, 4'd4});
    mq.delete();
    mq.push_back({3'd0, 4'd1});
    set_matches();
    obs_hit_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dut_rst && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_run_reached", dut_rst, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tbl.delete();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_inject", inject_sel, 0);
    chk("t5_dut_rst", dut_rst, 1);
    chk("t5_excl_count", excl_count, 0);
    for (int k = 0; k < 12; k++) @(negedge clk);
    chk("t5_no_hit", obs_hit_q.size(), 0);
    chk("t5_idle_held", busy, 0);

    // 6: random matches; start while busy ignored; restart from DONE with a same-cycle write
    mq.delete();
    for (int k = 0; k < 2; k++) mq.push_back({3'($urandom_range(0, 7)), 4'($urandom_range(1, MAXC))});
    set_matches();
    sweep("t6a", 1'b0, '0, $urandom_range(20, 200), 1'b0, '0);
    q = rand_pair();
    sweep("t6b", 1'b1, q, -1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
